// File: rtl/dma_multich_if.sv
// AXI-style read/write bus bundle between the multi-channel DMA engine and memory.
// The master modport is the engine side; the slave modport is the memory side.
interface dma_multich_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic              w_last;
  logic              b_valid;
  logic              b_err;

  modport master (
    output ar_valid, ar_addr, ar_len, aw_valid, aw_addr, aw_len,
           w_valid, w_data, w_last,
    input  ar_ready, r_valid, r_data, aw_ready, w_ready, b_valid, b_err
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, aw_valid, aw_addr, aw_len,
           w_valid, w_data, w_last,
    output ar_ready, r_valid, r_data, aw_ready, w_ready, b_valid, b_err
  );
endinterface

// File: rtl/dma_multich.sv
// Multi-channel DMA: splits per-channel copies into 4 KB-safe INCR bursts and
// serves enabled channels round-robin, one burst per turn.
module dma_multich #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
  dma_multich_if.master     bus,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] irq,
  output logic [NUM_CH-1:0] err
);
  localparam int BSH  = $clog2(DATA_W / 8);
  localparam int BA_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_RD, S_AW, S_WR, S_B, S_UPD} state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] src [NUM_CH];
  logic [ADDR_W-1:0] dst [NUM_CH];
  logic [LEN_W-1:0]  len [NUM_CH];
  logic [NUM_CH-1:0] en, irq_r, err_r;

  logic [CH_W-1:0]   cur_ch, rr_ptr, pick_ch, cand;
  logic              pick_vld, pick_zero, cfg_locked;
  logic [8:0]        pick_beats, beats_q, idx, last_idx;
  logic [7:0]        len_q;
  logic [ADDR_W-1:0] ar_addr_q, aw_addr_q, step;
  logic [DATA_W-1:0] burst_mem [MAX_BURST];

  // Beats allowed before the shortest of: remaining length, buffer depth, or either 4 KB page end.
  function automatic logic [8:0] calc_beats(input logic [ADDR_W-1:0] s,
                                            input logic [ADDR_W-1:0] d,
                                            input logic [LEN_W-1:0]  l);
    logic [12:0] sw, dw;
    logic [31:0] m;
    sw = (13'h1000 - {1'b0, s[11:0]}) >> BSH;
    dw = (13'h1000 - {1'b0, d[11:0]}) >> BSH;
    m  = MAX_BURST;
    if ({19'd0, sw} < m) m = {19'd0, sw};
    if ({19'd0, dw} < m) m = {19'd0, dw};
    if (32'(l) < m) m = 32'(l);
    return m[8:0];
  endfunction

  function automatic logic [CH_W-1:0] ch_next(input logic [CH_W-1:0] c);
    if (int'(c) >= NUM_CH - 1) return '0;
    return c + 1'b1;
  endfunction

  // Round-robin search starting at the channel after the last one served.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    cand     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!pick_vld && en[cand]) begin
        pick_vld = 1'b1;
        pick_ch  = cand;
      end
    end
  end

  assign pick_zero  = pick_vld && (len[pick_ch] == '0);
  assign pick_beats = calc_beats(src[pick_ch], dst[pick_ch], len[pick_ch]);
  assign last_idx   = beats_q - 9'd1;
  assign step       = ADDR_W'(beats_q) << BSH;
  assign cfg_locked = ((state != S_IDLE) && (cfg_ch == cur_ch)) ||
                      ((state == S_IDLE) && pick_vld && (cfg_ch == pick_ch));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (pick_vld && !pick_zero)                state_n = S_AR;
      S_AR:   if (bus.ar_ready)                          state_n = S_RD;
      S_RD:   if (bus.r_valid && (idx == last_idx))      state_n = S_AW;
      S_AW:   if (bus.aw_ready)                          state_n = S_WR;
      S_WR:   if (bus.w_ready && (idx == last_idx))      state_n = S_B;
      S_B:    if (bus.b_valid)                           state_n = S_UPD;
      S_UPD:                                             state_n = S_IDLE;
      default:                                           state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cur_ch    <= '0;
      rr_ptr    <= '0;
      beats_q   <= '0;
      len_q     <= '0;
      idx       <= '0;
      ar_addr_q <= '0;
      aw_addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (pick_vld) begin
          cur_ch <= pick_ch;
          idx    <= '0;
          if (pick_zero) begin
            rr_ptr <= ch_next(pick_ch);
          end else begin
            beats_q   <= pick_beats;
            len_q     <= 8'(pick_beats - 9'd1);
            ar_addr_q <= src[pick_ch];
            aw_addr_q <= dst[pick_ch];
          end
        end
        S_RD:  if (bus.r_valid) idx <= (idx == last_idx) ? '0 : idx + 9'd1;
        S_WR:  if (bus.w_ready) idx <= idx + 9'd1;
        S_UPD: rr_ptr <= ch_next(cur_ch);
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (state == S_RD && bus.r_valid) burst_mem[idx[BA_W-1:0]] <= bus.r_data;
  end

  // Later assignments win: completion/error updates override config, irq set overrides clear.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        src[i] <= '0;
        dst[i] <= '0;
        len[i] <= '0;
      end
      en    <= '0;
      irq_r <= '0;
      err_r <= '0;
    end else begin
      if (cfg_we) begin
        if (cfg_sel == 2'd3) begin
          en[cfg_ch] <= cfg_wdata[0];
          if (cfg_wdata[1]) irq_r[cfg_ch] <= 1'b0;
        end else if (!cfg_locked) begin
          case (cfg_sel)
            2'd0:    src[cfg_ch] <= cfg_wdata;
            2'd1:    dst[cfg_ch] <= cfg_wdata;
            default: len[cfg_ch] <= cfg_wdata[LEN_W-1:0];
          endcase
        end
      end
      if (state == S_IDLE && pick_zero) begin
        irq_r[pick_ch] <= 1'b1;
        en[pick_ch]    <= 1'b0;
      end
      // Channel state is settled on the write response so irq is visible the next cycle.
      if (state == S_B && bus.b_valid) begin
        if (bus.b_err) begin
          err_r[cur_ch] <= 1'b1;
          irq_r[cur_ch] <= 1'b1;
          en[cur_ch]    <= 1'b0;
        end else begin
          src[cur_ch] <= src[cur_ch] + step;
          dst[cur_ch] <= dst[cur_ch] + step;
          len[cur_ch] <= len[cur_ch] - LEN_W'(beats_q);
          if (len[cur_ch] == LEN_W'(beats_q)) begin
            irq_r[cur_ch] <= 1'b1;
            en[cur_ch]    <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) busy[i] = en[i] && (len[i] != '0);
  end

  assign irq          = irq_r;
  assign err          = err_r;
  assign bus.ar_valid = (state == S_AR);
  assign bus.ar_addr  = ar_addr_q;
  assign bus.ar_len   = len_q;
  assign bus.aw_valid = (state == S_AW);
  assign bus.aw_addr  = aw_addr_q;
  assign bus.aw_len   = len_q;
  assign bus.w_valid  = (state == S_WR);
  assign bus.w_data   = (state == S_WR) ? burst_mem[idx[BA_W-1:0]] : '0;
  assign bus.w_last   = (state == S_WR) && (idx == last_idx);
endmodule

// File: tb/tb_dma_multich.sv
// Directed bench for dma_multich: bus-slave models with a write memory, scenario tasks with inline checks.
module tb_dma_multich;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic [1:0]  busy, irq, err;

  dma_multich_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dma_multich #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_BURST(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .bus(bus), .busy(busy), .irq(irq), .err(err)
  );

  always #5 ACLK = ~ACLK;

  int vec = 0;
  int miss = 0;

  logic [31:0] ar_log[$];
  logic [7:0]  arlen_log[$];
  logic [31:0] aw_log[$];
  logic [7:0]  awlen_log[$];
  logic [31:0] wmem [logic [31:0]];
  int          wlast_bad = 0;
  bit          throttle = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Read slave: accepts every AR at once, streams beats (every other cycle when throttled).
  initial begin
    logic [31:0] rd_addr;
    int rd_left;
    bit rgap;
    rd_addr = 0; rd_left = 0; rgap = 0;
    bus.ar_ready = 1'b1; bus.r_valid = 1'b0; bus.r_data = '0;
    forever begin
      @(negedge ACLK);
      bus.r_valid = 1'b0;
      rgap = ~rgap;
      if (!ARESETn) rd_left = 0;
      else if (rd_left > 0) begin
        if (!(throttle && rgap)) begin
          bus.r_valid = 1'b1;
          bus.r_data  = src_word(rd_addr);
          rd_addr += 4;
          rd_left--;
        end
      end else if (bus.ar_valid) begin
        ar_log.push_back(bus.ar_addr);
        arlen_log.push_back(bus.ar_len);
        rd_addr = bus.ar_addr;
        rd_left = int'(bus.ar_len) + 1;
      end
    end
  end

  // Write slave: stores beats into wmem, checks w_last placement, answers with one B.
  initial begin
    logic [31:0] wr_addr, wr_base;
    int wr_idx, wr_len;
    bit b_pend, tog;
    wr_addr = 0; wr_base = 0; wr_idx = 0; wr_len = 0; b_pend = 0; tog = 0;
    bus.aw_ready = 1'b1; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_err = 1'b0;
    forever begin
      @(negedge ACLK);
      bus.b_valid = 1'b0;
      bus.b_err   = 1'b0;
      if (!ARESETn) begin
        b_pend = 0; bus.w_ready = 1'b0;
      end else begin
        if (b_pend) begin
          bus.b_valid = 1'b1;
          bus.b_err   = (wr_base == err_addr);
          b_pend = 0;
        end
        tog = ~tog;
        bus.w_ready = throttle ? tog : 1'b1;
        if (bus.w_valid && bus.w_ready) begin
          wmem[wr_addr] = bus.w_data;
          if (bus.w_last !== (wr_idx == wr_len)) wlast_bad++;
          wr_addr += 4;
          wr_idx++;
          if (wr_idx > wr_len) b_pend = 1;
        end
        if (bus.aw_valid) begin
          aw_log.push_back(bus.aw_addr);
          awlen_log.push_back(bus.aw_len);
          wr_base = bus.aw_addr; wr_addr = bus.aw_addr;
          wr_len = int'(bus.aw_len); wr_idx = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cfg_write(input int ch, input int sel, input logic [31:0] d);
    @(negedge ACLK);
    cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_sel = 2'(sel); cfg_wdata = d;
    @(negedge ACLK);
    cfg_we = 1'b0;
  endtask

  task automatic wait_irq(input int ch, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      if (irq[ch]) begin ok = 1; break; end
    end
  endtask

  task automatic clear_logs();
    ar_log.delete(); arlen_log.delete(); aw_log.delete(); awlen_log.delete();
    wlast_bad = 0;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_wdata = '0;
    repeat (3) @(negedge ACLK);
    vec++; if (bus.ar_valid !== 1'b0) begin miss++; $display("FAIL rst_ar_valid got %b want 0", bus.ar_valid); end
    vec++; if (bus.aw_valid !== 1'b0) begin miss++; $display("FAIL rst_aw_valid got %b want 0", bus.aw_valid); end
    vec++; if (bus.w_valid !== 1'b0) begin miss++; $display("FAIL rst_w_valid got %b want 0", bus.w_valid); end
    vec++; if (bus.w_last !== 1'b0) begin miss++; $display("FAIL rst_w_last got %b want 0", bus.w_last); end
    vec++; if (bus.ar_addr !== 32'h0) begin miss++; $display("FAIL rst_ar_addr got %h want 0", bus.ar_addr); end
    vec++; if (bus.ar_len !== 8'h0) begin miss++; $display("FAIL rst_ar_len got %h want 0", bus.ar_len); end
    vec++; if (busy !== 2'b00) begin miss++; $display("FAIL rst_busy got %b want 00", busy); end
    vec++; if (irq !== 2'b00) begin miss++; $display("FAIL rst_irq got %b want 00", irq); end
    vec++; if (err !== 2'b00) begin miss++; $display("FAIL rst_err got %b want 00", err); end
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    cfg_write(0, 0, 32'h1000);
    cfg_write(0, 1, 32'h2000);
    cfg_write(0, 2, 32'd4);
    cfg_write(0, 3, 32'h1);
    vec++; if (bus.ar_valid !== 1'b0) begin miss++; $display("FAIL single_ar_n1 got %b want 0", bus.ar_valid); end
    @(negedge ACLK);
    vec++; if (bus.ar_valid !== 1'b1) begin miss++; $display("FAIL single_ar_n2 got %b want 1", bus.ar_valid); end
    vec++; if (busy[0] !== 1'b1) begin miss++; $display("FAIL single_busy_run got %b want 1", busy[0]); end
    wait_irq(0, 500, ok);
    vec++; if (!ok) begin miss++; $display("FAIL single_done got timeout want irq0"); end
    vec++; if (ar_log.size() != 1 || ar_log[0] !== 32'h1000 || arlen_log[0] !== 8'd3) begin
      miss++; $display("FAIL single_ar got n=%0d want one AR 0x1000 len 3", ar_log.size()); end
    vec++; if (aw_log.size() != 1 || aw_log[0] !== 32'h2000 || awlen_log[0] !== 8'd3) begin
      miss++; $display("FAIL single_aw got n=%0d want one AW 0x2000 len 3", aw_log.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h2000 + 32'(4 * i);
      vec++; if (!wmem.exists(a) || wmem[a] !== src_word(32'h1000 + 32'(4 * i))) begin
        miss++; $display("FAIL single_data[%0d] got missing/wrong want %h", i, src_word(32'h1000 + 32'(4 * i))); end
    end
    vec++; if (wlast_bad != 0) begin miss++; $display("FAIL single_wlast got %0d bad beats want 0", wlast_bad); end
    vec++; if (busy[0] !== 1'b0) begin miss++; $display("FAIL single_busy_end got %b want 0", busy[0]); end
    cfg_write(0, 3, 32'h2);
    vec++; if (irq[0] !== 1'b0) begin miss++; $display("FAIL single_irq_clr got %b want 0", irq[0]); end
  endtask

  task automatic test_multi_burst();
    bit ok;
    logic [31:0] exp_ar [3] = '{32'h3000, 32'h3040, 32'h3080};
    logic [31:0] exp_aw [3] = '{32'h8000, 32'h8040, 32'h8080};
    logic [7:0]  exp_ln [3] = '{8'd15, 8'd15, 8'd7};
    int bad;
    clear_logs();
    throttle = 1;
    cfg_write(0, 0, 32'h3000);
    cfg_write(0, 1, 32'h8000);
    cfg_write(0, 2, 32'd40);
    cfg_write(0, 3, 32'h3);
    wait_irq(0, 3000, ok);
    vec++; if (!ok) begin miss++; $display("FAIL multi_done got timeout want irq0"); end
    vec++; if (ar_log.size() != 3) begin miss++; $display("FAIL multi_nbursts got %0d want 3", ar_log.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < ar_log.size() && i < aw_log.size()) begin
        vec++; if (ar_log[i] !== exp_ar[i] || arlen_log[i] !== exp_ln[i] || aw_log[i] !== exp_aw[i]) begin
          miss++; $display("FAIL multi_burst[%0d] got ar %h len %0d aw %h want ar %h len %0d aw %h",
                           i, ar_log[i], arlen_log[i], aw_log[i], exp_ar[i], exp_ln[i], exp_aw[i]); end
      end
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'h8000 + 32'(4 * i);
      if (!wmem.exists(a) || wmem[a] !== src_word(32'h3000 + 32'(4 * i))) bad++;
    end
    vec++; if (bad != 0) begin miss++; $display("FAIL multi_data got %0d wrong words want 0", bad); end
    vec++; if (wlast_bad != 0) begin miss++; $display("FAIL multi_wlast got %0d bad beats want 0", wlast_bad); end
    throttle = 0;
    cfg_write(0, 2, 32'd1);
    cfg_write(0, 3, 32'h3);
    wait_irq(0, 500, ok);
    vec++; if (!ok || ar_log.size() != 4 || ar_log[3] !== 32'h30A0 || aw_log[3] !== 32'h80A0 || arlen_log[3] !== 8'd0) begin
      miss++; $display("FAIL multi_final_ptr got n=%0d want AR 0x30A0 AW 0x80A0 len 0", ar_log.size()); end
  endtask

  task automatic test_4k_split();
    bit ok;
    int bad;
    clear_logs();
    cfg_write(0, 0, 32'h0FF8);
    cfg_write(0, 1, 32'h5000);
    cfg_write(0, 2, 32'd8);
    cfg_write(0, 3, 32'h3);
    wait_irq(0, 800, ok);
    vec++; if (!ok) begin miss++; $display("FAIL split_done got timeout want irq0"); end
    vec++; if (ar_log.size() != 2) begin miss++; $display("FAIL split_nbursts got %0d want 2", ar_log.size()); end
    if (ar_log.size() == 2 && aw_log.size() == 2) begin
      vec++; if (ar_log[0] !== 32'h0FF8 || arlen_log[0] !== 8'd1) begin
        miss++; $display("FAIL split_first got %h len %0d want 00000ff8 len 1", ar_log[0], arlen_log[0]); end
      vec++; if (ar_log[1] !== 32'h1000 || arlen_log[1] !== 8'd5 || aw_log[1] !== 32'h5008) begin
        miss++; $display("FAIL split_second got %h len %0d aw %h want 00001000 len 5 aw 00005008",
                         ar_log[1], arlen_log[1], aw_log[1]); end
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = 32'h5000 + 32'(4 * i);
      if (!wmem.exists(a) || wmem[a] !== src_word(32'h0FF8 + 32'(4 * i))) bad++;
    end
    vec++; if (bad != 0) begin miss++; $display("FAIL split_data got %0d wrong words want 0", bad); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int bad;
    logic [31:0] exp_ar [4] = '{32'h10000, 32'h30000, 32'h10040, 32'h30040};
    clear_logs();
    cfg_write(0, 0, 32'h10000); cfg_write(0, 1, 32'h20000); cfg_write(0, 2, 32'd32);
    cfg_write(1, 0, 32'h30000); cfg_write(1, 1, 32'h40000); cfg_write(1, 2, 32'd32);
    cfg_write(0, 3, 32'h3);
    cfg_write(1, 3, 32'h3);
    wait_irq(0, 2000, ok);
    vec++; if (!ok || irq[1] !== 1'b0) begin miss++; $display("FAIL rr_ch0_first got ok=%0d irq=%b want ok=1 irq=01", ok, irq); end
    wait_irq(1, 2000, ok);
    vec++; if (!ok) begin miss++; $display("FAIL rr_ch1_done got timeout want irq1"); end
    vec++; if (ar_log.size() != 4) begin miss++; $display("FAIL rr_nbursts got %0d want 4", ar_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < ar_log.size()) begin
        vec++; if (ar_log[i] !== exp_ar[i]) begin
          miss++; $display("FAIL rr_order[%0d] got %h want %h", i, ar_log[i], exp_ar[i]); end
      end
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (wmem[32'h20000 + 32'(4 * i)] !== src_word(32'h10000 + 32'(4 * i))) bad++;
      if (wmem[32'h40000 + 32'(4 * i)] !== src_word(32'h30000 + 32'(4 * i))) bad++;
    end
    vec++; if (bad != 0) begin miss++; $display("FAIL rr_data got %0d wrong words want 0", bad); end
  endtask

  task automatic test_bresp_error();
    bit ok;
    int bad;
    clear_logs();
    err_addr = 32'h71000;
    cfg_write(0, 0, 32'h50000); cfg_write(0, 1, 32'h60000); cfg_write(0, 2, 32'd32);
    cfg_write(1, 0, 32'h70000); cfg_write(1, 1, 32'h71000); cfg_write(1, 2, 32'd16);
    cfg_write(0, 3, 32'h3);
    cfg_write(1, 3, 32'h3);
    wait_irq(0, 2000, ok);
    vec++; if (!ok) begin miss++; $display("FAIL berr_ch0_done got timeout want irq0"); end
    vec++; if (err !== 2'b10) begin miss++; $display("FAIL berr_err got %b want 10", err); end
    vec++; if (irq[1] !== 1'b1 || busy[1] !== 1'b0) begin
      miss++; $display("FAIL berr_ch1_state got irq1=%b busy1=%b want 1 0", irq[1], busy[1]); end
    vec++; if (ar_log.size() != 3 || ar_log[1] !== 32'h70000) begin
      miss++; $display("FAIL berr_bursts got n=%0d want 3 with ch1 second", ar_log.size()); end
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (wmem[32'h60000 + 32'(4 * i)] !== src_word(32'h50000 + 32'(4 * i))) bad++;
    vec++; if (bad != 0) begin miss++; $display("FAIL berr_ch0_data got %0d wrong words want 0", bad); end
    err_addr = 32'hFFFF_FFFF;
    cfg_write(1, 3, 32'h3);
    wait_irq(1, 1000, ok);
    vec++; if (!ok || ar_log.size() != 4 || ar_log[3] !== 32'h70000 || arlen_log[3] !== 8'd15) begin
      miss++; $display("FAIL berr_retry got n=%0d want AR 0x70000 len 15 (regs unchanged)", ar_log.size()); end
  endtask

  task automatic test_len0_and_reset();
    int saw_ar;
    bit ok;
    clear_logs();
    cfg_write(1, 2, 32'd0);
    cfg_write(1, 3, 32'h3);
    saw_ar = 0;
    repeat (2) begin
      @(negedge ACLK);
      if (bus.ar_valid) saw_ar++;
    end
    vec++; if (irq[1] !== 1'b1 || saw_ar != 0 || busy[1] !== 1'b0) begin
      miss++; $display("FAIL len0 got irq1=%b ar_cycles=%0d busy1=%b want 1 0 0", irq[1], saw_ar, busy[1]); end
    throttle = 1;
    cfg_write(0, 0, 32'h90000); cfg_write(0, 1, 32'hA0000); cfg_write(0, 2, 32'd16);
    cfg_write(0, 3, 32'h3);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ACLK);
      if (bus.w_valid) begin ok = 1; break; end
    end
    vec++; if (!ok) begin miss++; $display("FAIL rst_mid_reach got timeout want w_valid"); end
    #2 ARESETn = 1'b0;
    #1;
    vec++; if (bus.ar_valid !== 1'b0 || bus.aw_valid !== 1'b0 || bus.w_valid !== 1'b0 || bus.w_last !== 1'b0) begin
      miss++; $display("FAIL rst_mid_valids got ar%b aw%b w%b last%b want 0000",
                       bus.ar_valid, bus.aw_valid, bus.w_valid, bus.w_last); end
    vec++; if (bus.ar_addr !== 32'h0 || bus.aw_addr !== 32'h0 || bus.ar_len !== 8'h0 || bus.aw_len !== 8'h0) begin
      miss++; $display("FAIL rst_mid_addr got %h %h %h %h want zeros",
                       bus.ar_addr, bus.aw_addr, bus.ar_len, bus.aw_len); end
    vec++; if (bus.w_data !== 32'h0) begin miss++; $display("FAIL rst_mid_wdata got %h want 0", bus.w_data); end
    vec++; if (busy !== 2'b00 || irq !== 2'b00 || err !== 2'b00) begin
      miss++; $display("FAIL rst_mid_status got busy=%b irq=%b err=%b want 00 00 00", busy, irq, err); end
    throttle = 0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);
    vec++; if (bus.ar_valid !== 1'b0 || busy !== 2'b00) begin
      miss++; $display("FAIL rst_after got ar_valid=%b busy=%b want 0 00", bus.ar_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_burst();
    test_4k_split();
    test_round_robin();
    test_bresp_error();
    test_len0_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/dma_multich.md
# dma_multich

Parametrised multi-channel DMA engine: next generation of the single-channel, single-burst DMA core. Each of NUM_CH channels holds its own source, destination and word-count registers. The engine splits arbitrary-length copies into AXI-legal INCR bursts of at most MAX_BURST beats, never crossing a 4 KB boundary, and interleaves enabled channels round-robin at burst granularity. It sits between the DMA slave config FSM and the DMA master FSM, and raises per-channel interrupts to the CPU.

## Interface
- NUM_CH, 2: channel count, 1..8.
- ADDR_W, 32: byte address width.
- DATA_W, 32: beat width; words are DATA_W/8 bytes.
- LEN_W, 16: per-channel word-count width.
- MAX_BURST, 16: maximum beats per burst and burst-buffer depth, power of two, ≤256.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  clog2(NUM_CH)  channel select.
- cfg_sel  in  2  register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL.
- cfg_wdata  in  ADDR_W  write data. CTRL bit0 = enable, bit1 = irq clear (W1C).
- ar_valid / ar_ready  out / in  1  read address handshake.
- ar_addr  out  ADDR_W  burst source address.
- ar_len  out  8  beats-1.
- r_valid  in  1  read beat valid. The engine always accepts read beats.
- r_data  in  DATA_W  read beat data.
- aw_valid / aw_ready  out / in  1  write address handshake.
- aw_addr  out  ADDR_W  burst destination address.
- aw_len  out  8  beats-1.
- w_valid / w_ready  out / in  1  write beat handshake.
- w_data  out  DATA_W  write beat data.
- w_last  out  1  last beat of the burst.
- b_valid  in  1  write response valid.
- b_err  in  1  write response error (SLVERR/DECERR).
- busy  out  NUM_CH  channel enabled and words remaining.
- irq  out  NUM_CH  sticky done/error interrupt, one per channel.
- err  out  NUM_CH  sticky error flag, one per channel.

## Operation
- FSM states: IDLE, AR, RD, AW, WR, B, UPD.
- IDLE: round-robin pick from channels with enable=1.
  - The pointer starts after the last-served channel; after reset it starts at channel 0.
  - A picked channel with LEN=0 sets its irq, clears its enable, and returns to IDLE without any bus traffic.
- Burst size: beats = min(LEN, MAX_BURST, words to the next 4 KB boundary of SRC, words to the next 4 KB boundary of DST). Computed in IDLE and latched.
- AR: assert ar_valid with the latched ar_addr/ar_len until ar_ready, then go to RD.
- RD: each r_valid writes r_data into the burst buffer at the write index. After `beats` beats, go to AW.
- AW: assert aw_valid until aw_ready, then go to WR.
- WR: w_data comes from the buffer at the read index. The index advances on w_valid&w_ready. w_last=1 on beat beats-1. After the last beat, go to B.
- B: wait for b_valid.
- UPD: SRC += beats·DATA_W/8, DST += beats·DATA_W/8, LEN -= beats.
  - If LEN reaches 0: set irq, clear enable.
  - If b_err: set err and irq, clear enable, leave SRC/DST/LEN unchanged.
  - Return to IDLE and advance the round-robin pointer.
- Config writes to SRC/DST/LEN of the channel currently in a burst are ignored. Writes to idle channels take effect immediately.
- CTRL enable=0 on the active channel (abort): the burst completes, UPD still runs, then the channel stays disabled.
- irq clear and irq set in the same cycle: set wins.
- Arithmetic: addresses wrap modulo 2^ADDR_W. LEN never underflows.
- busy[i] = enable[i] & (LEN[i]≠0).

## Timing
- Reset values:
  - Outputs: ar_valid, aw_valid, w_valid, w_last = 0; ar_addr, aw_addr, ar_len, aw_len, w_data = 0; busy, irq, err = 0.
  - All channel registers = 0; FSM in IDLE; round-robin pointer at channel 0.
- Reset is asynchronous and takes effect mid-burst. Outstanding bus transactions are abandoned.
- Enable write in cycle N → ar_valid high in cycle N+2 (IDLE pick in N+1) if the engine is idle.
- The first w_valid comes 1 cycle after the aw handshake. w_valid stays high every cycle until w_ready, giving a back-to-back rate of 1 beat per cycle.
- irq rises 1 cycle after the b_valid that completes the final burst.
- Minimum per-burst overhead: 4 idle cycles (IDLE, UPD, and one cycle each for the AR and AW handshakes).

## Test plan
- Ch0: SRC=0x1000, DST=0x2000, LEN=4, enable → one burst with ar_len=3 and aw_len=3. Data copied in order, w_last on beat 3, irq[0]=1, busy[0]=0.
- Ch0 LEN=40, MAX_BURST=16 → three bursts of 16, 16 and 8 beats. Addresses advance by 0x40 per 16-beat burst; final SRC=SRC+0xA0.
- SRC=0x0FF8, LEN=8 → burst of 2 beats, then a burst of 6 beats starting at 0x1000, with no 4 KB crossing.
- Ch0 and ch1 both enabled with LEN=32 → bursts alternate ch0, ch1, ch0, ch1. Both irqs set; ch0 finishes first.
- b_err=1 on ch1's first burst → err[1]=1, irq[1]=1, ch1 disabled, ch0 completes normally.
- LEN=0 enable → irq set within 2 cycles with no ar_valid. Then assert ARESETn low mid-burst of another channel → all outputs return to reset values immediately.
